// File: rtl/rv_mc_perf_monitor.sv
// rtl/rv_mc_perf_monitor.sv - cycle/instruction/CPI performance monitor for the multicycle core
//
// Purpose: counts enabled cycles, started instructions, per-class instruction
// counts and per-class cycle totals from the core's fetch strobe. It flags
// program completion when one PC is fetched HALT_REPEAT+1 times in a row.
// Every counter saturates at all-ones.
//
// Ports:
//   clk      core clock
//   rst      asynchronous active-low reset
//   en       counting enable (core running)
//   clear    synchronous clear of counters and halt state, wins over fetch
//   fetch    one-cycle instruction fetch strobe
//   opcode   fetched opcode, RD[6:0]
//   pc       PC of the fetched instruction
//   rd_sel   counter select: 0 cyc, 1 ins, 2-9 cnt[0..7], 10-17 cyc_c[0..7]
//   rd_data  registered value of the selected counter
//   halted   sticky completion flag
module rv_mc_perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int HALT_REPEAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             fetch,
  input  logic [6:0]       opcode,
  input  logic [31:0]      pc,
  input  logic [4:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             halted
);

  localparam int REP_W = $clog2(HALT_REPEAT + 1);
  localparam logic [REP_W-1:0] REP_LIM = REP_W'(HALT_REPEAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             run, go, track_close, halt_hit;
  logic [2:0]       cls, cur_cls_q;
  logic [REP_W-1:0] rep_q, rep_inc;
  logic [31:0]      last_pc_q;
  logic [CNT_W-1:0] cyc_q, ins_q, start_q, delta, rd_mux;
  logic [CNT_W-1:0] cnt_q   [8];
  logic [CNT_W-1:0] cyc_c_q [8];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  function automatic logic [2:0] op_class(input logic [6:0] op);
    case (op)
      7'b0110011: return 3'd0;
      7'b0010011: return 3'd1;
      7'b0000011: return 3'd2;
      7'b0100011: return 3'd3;
      7'b1100011: return 3'd4;
      7'b1101111: return 3'd5;
      7'b0110111: return 3'd6;
      default:    return 3'd7;
    endcase
  endfunction

  assign cls      = op_class(opcode);
  assign rep_inc  = rep_q + REP_W'(1);
  assign halt_hit = (pc == last_pc_q) && (rep_inc == REP_LIM);
  // cyc never falls behind start, so the plain unsigned difference is exact.
  assign delta    = cyc_q - start_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_TRACK: if (fetch && en) state_d = halt_hit ? S_HALT : S_TRACK;
        S_HALT:          state_d = S_HALT;
        default:         state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    run         = en && (state_q != S_HALT);
    go          = run && fetch;
    track_close = go && (state_q == S_TRACK);
    halted      = (state_q == S_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || clear) begin
      // Reset and clear share one path; clear is checked before fetch so a
      // simultaneous fetch is dropped.
      cyc_q     <= '0;
      ins_q     <= '0;
      start_q   <= '0;
      cur_cls_q <= '0;
      rep_q     <= '0;
      last_pc_q <= 32'hFFFF_FFFF;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i]   <= '0;
        cyc_c_q[i] <= '0;
      end
    end else if (run) begin
      cyc_q <= sat_inc(cyc_q);
      if (go) begin
        if (track_close) cyc_c_q[cur_cls_q] <= sat_add(cyc_c_q[cur_cls_q], delta);
        start_q    <= cyc_q;
        cur_cls_q  <= cls;
        cnt_q[cls] <= sat_inc(cnt_q[cls]);
        ins_q      <= sat_inc(ins_q);
        if (pc == last_pc_q) begin
          rep_q <= rep_inc;
        end else begin
          rep_q     <= '0;
          last_pc_q <= pc;
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (rd_sel == 5'd0)       rd_mux = cyc_q;
    else if (rd_sel == 5'd1)  rd_mux = ins_q;
    else if (rd_sel <= 5'd9)  rd_mux = cnt_q[3'(rd_sel - 5'd2)];
    else if (rd_sel <= 5'd17) rd_mux = cyc_c_q[3'(rd_sel - 5'd10)];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= rd_mux;
  end

endmodule

// File: doc/rv_mc_perf_monitor.md
# rv_mc_perf_monitor

Hardware performance monitor attached downstream of the multicycle core (`rv_mc`). It consumes the core's fetch strobe, fetched opcode and PC, and keeps cycle, instruction and per-class cycle-per-instruction counters. It also detects program completion as a self-loop on one PC and exposes every counter through a registered read port. It replaces bench-side CPI bookkeeping with synthesizable logic usable on silicon and in simulation.

## Interface
- `CNT_W`, default 32: width of every counter and of `rd_data`.
- `HALT_REPEAT`, default 2: number of consecutive same-PC fetch repeats that declares halt.
- `clk  in  1`: core clock; all state changes on its rising edge.
- `rst  in  1`: asynchronous, active-low reset; it asserts immediately and releases synchronously to `clk`.
- `en  in  1`: counting enable; the core is running.
- `clear  in  1`: synchronous clear of all counters and halt state.
- `fetch  in  1`: one-cycle strobe; an instruction is latched into the IR while the FSM is in FETCH (`we_ir` qualified by state 0).
- `opcode  in  7`: `RD[6:0]`, sampled when `fetch` = 1.
- `pc  in  32`: PC of the fetched instruction, sampled when `fetch` = 1.
- `rd_sel  in  5`: counter select.
- `rd_data  out  CNT_W`: registered value of the selected counter.
- `halted  out  1`: sticky program-completion flag.

## Operation
- Opcode class codes:
  - R = 0110011 → class 0
  - I-arith = 0010011 → class 1
  - load = 0000011 → class 2
  - store = 0100011 → class 3
  - branch = 1100011 → class 4
  - JAL = 1101111 → class 5
  - LUI = 0110111 → class 6
  - any other opcode → class 7
- Counters:
  - `cyc`: counts enabled cycles.
  - `ins`: counts retired-and-started instructions.
  - `cnt[0..7]`: per-class instruction counts.
  - `cyc_c[0..7]`: per-class cycle totals.
  - Internal registers: `start`, `cur_cls`, `last_pc`, `rep`.
- FSM states:
  - IDLE: no instruction in flight.
  - TRACK: one instruction in flight.
  - HALT: frozen.
- IDLE → TRACK on `fetch & en`.
  - Action: `start`←`cyc`, `cur_cls`←class(`opcode`), `cnt[cls]`++, `ins`++.
- TRACK on `fetch & en`:
  - First, `cyc_c[cur_cls]` += (`cyc` − `start`), using pre-edge values. This closes the previous instruction.
  - Then the same start action as IDLE → TRACK.
- `cyc` increments on every edge with `en` = 1 in IDLE or TRACK. This includes the fetch edge.
- Halt detection on each `fetch & en`:
  - If `pc` == `last_pc`, `rep`++.
  - Otherwise `rep`←0 and `last_pc`←`pc`.
  - When the incremented `rep` reaches `HALT_REPEAT`, go to HALT and set `halted`=1.
  - The halting fetch is still fully accounted: it closes the previous instruction and counts the new one.
- HALT: all counters frozen; `fetch` and `en` are ignored. Only `clear` or `rst` leaves HALT.
- `clear` = 1: every counter, `rep`, `start` and `halted` go to 0, `last_pc` goes to 32'hFFFFFFFF, and the FSM goes to IDLE. `clear` has priority over `fetch` in the same cycle.
- `en` = 0: no counter or FSM change. A `fetch` arriving while `en` = 0 is ignored.
- Arithmetic:
  - All counters saturate at all-ones and never wrap.
  - The delta `cyc` − `start` is an unsigned `CNT_W` subtraction; `cyc` ≥ `start` always holds.
- `rd_sel` map:
  - 0: `cyc`
  - 1: `ins`
  - 2–9: `cnt[0..7]`
  - 10–17: `cyc_c[0..7]`
  - 18–31: return 0

## Timing
- Reset values:
  - `rd_data`=0, `halted`=0.
  - All counters 0, `last_pc`=32'hFFFFFFFF, FSM=IDLE.
- `rst` assertion mid-instruction discards the in-flight instruction; nothing is added to `cyc_c`.
- Counter update latency: a `fetch` sampled at edge k updates counters at edge k.
- Read latency:
  - `rd_data` reflects the counter value as of edge k−1, sampled with the `rd_sel` presented before edge k.
  - `rd_sel` → `rd_data` is 1 cycle.
  - A counter updated at edge k is readable at edge k+1.
- `halted` rises at the same edge as the halting fetch.
- Simultaneous `fetch` and `clear`: `clear` wins, and that fetch is not counted.
- Back-to-back fetches on consecutive cycles are legal, giving a 1-cycle instruction delta.

## Test plan
- Reset check: `rst`=0 mid-run → `halted`=0, all 18 selectable counters read 0, and 18–31 read 0.
- R-type CPI: `en`=1, R-type fetches every 4 cycles at PC 0, 4, 8 → `cnt[0]`=3 and `cyc_c[0]`=8, with the third instruction still open. `ins`=3.
- Mixed classes: load (5-cycle), store (4), branch (3), then LUI fetch → `cyc_c[2]`=5, `cyc_c[3]`=4, `cyc_c[4]`=3, `cnt[6]`=1.
- Halt, default `HALT_REPEAT`: fetches at PC 0x40 three times consecutively → `halted`=1 on the third fetch. `cyc` then stays constant over 20 further cycles with `en`=1.
- Near-miss: fetches at PC 0x40, 0x40, 0x44, 0x40, 0x40 → `halted` stays 0.
- Clear and saturation:
  - `clear` with a simultaneous `fetch` → all counters 0 and FSM IDLE.
  - With `CNT_W`=4, run 20 enabled cycles → `cyc` reads 4'hF.
